// File: rtl/fir_block_driver.sv
// Stream adapter around the block FIR core: packs SAMPLES_NUM samples, starts the core,
// then quantizes and streams the results. Build option: FIR_DRIVER_ROUND_EN (round half up).
module fir_block_driver #(
    parameter int SAMPLES_NUM = 4,
    parameter int OUT_SHIFT   = 15
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic [15:0]               sampleIn,
    input  logic                      sampleValidIn,
    output logic                      sampleReadyOut,
    output logic                      firStartOut,
    input  logic                      firBusyIn,
    input  logic                      firDoneIn,
    output logic [16*SAMPLES_NUM-1:0] firDataOut,
    input  logic [32*SAMPLES_NUM-1:0] firDataIn,
    output logic [15:0]               resultOut,
    output logic                      resultValidOut,
    input  logic                      resultReadyIn,
    output logic                      resultSatOut
);
    localparam int IW = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
    localparam logic [IW-1:0] LAST = IW'(SAMPLES_NUM - 1);

    typedef enum logic [1:0] {COLLECT, START, WAIT, EMIT} state_t;

    state_t                    r_state;
    logic [IW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic [16*SAMPLES_NUM-1:0] r_fir_data;
    logic [32*SAMPLES_NUM-1:0] r_results;
    logic                      r_sample_ready;
    logic                      r_fir_start;
    logic [15:0]               r_result;
    logic                      r_result_valid;
    logic                      r_result_sat;

    logic                      w_sample_acc;
    logic                      w_result_acc;
    logic [IW-1:0]             w_next_idx;
    logic [31:0]               w_elem [2**IW];
    logic [16:0]               w_q_first;
    logic [16:0]               w_q_next;

    // Returns {saturated, value}; evaluated at 33 bits so rounding cannot overflow.
    function automatic logic [16:0] quant(input logic [31:0] e);
        logic signed [32:0] x;
        x = {e[31], e};
`ifdef FIR_DRIVER_ROUND_EN
        x = x + (33'sd1 <<< (OUT_SHIFT - 1));
`endif
        x = x >>> OUT_SHIFT;
        if (x > 33'sd32767)
            return {1'b1, 16'h7FFF};
        else if (x < -33'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, x[15:0]};
    endfunction

    // Element i lives in the i-th slot counted from the MSB end of the result word.
    genvar gi;
    generate
        for (gi = 0; gi < 2**IW; gi++) begin : g_elem
            if (gi < SAMPLES_NUM) begin : g_used
                assign w_elem[gi] = r_results[32*(SAMPLES_NUM-1-gi) +: 32];
            end else begin : g_pad
                assign w_elem[gi] = 32'd0;
            end
        end
    endgenerate

    assign w_sample_acc = sampleValidIn && r_sample_ready;
    assign w_result_acc = r_result_valid && resultReadyIn;
    assign w_next_idx   = r_idx + 1'b1;
    assign w_q_first    = quant(firDataIn[32*(SAMPLES_NUM-1) +: 32]);
    assign w_q_next     = quant(w_elem[w_next_idx]);

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            r_state        <= COLLECT;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_fir_data     <= '0;
            r_results      <= '0;
            r_sample_ready <= 1'b0;
            r_fir_start    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_sat   <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_sample_ready <= 1'b1;
                    if (w_sample_acc) begin
                        for (int k = 0; k < SAMPLES_NUM; k++)
                            if (r_cnt == IW'(k))
                                r_fir_data[16*k +: 16] <= sampleIn;
                        if (r_cnt == LAST) begin
                            r_cnt          <= '0;
                            r_sample_ready <= 1'b0;
                            r_fir_start    <= !firBusyIn;
                            r_state        <= START;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    // The pulse is on the wire this cycle when r_fir_start is set.
                    if (r_fir_start) begin
                        r_fir_start <= 1'b0;
                        r_state     <= WAIT;
                    end else begin
                        r_fir_start <= !firBusyIn;
                    end
                end
                WAIT: begin
                    if (firDoneIn) begin
                        r_results      <= firDataIn;
                        r_idx          <= '0;
                        r_result       <= w_q_first[15:0];
                        r_result_sat   <= w_q_first[16];
                        r_result_valid <= 1'b1;
                        r_state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_result_acc) begin
                        if (r_idx == LAST) begin
                            r_result_valid <= 1'b0;
                            r_result_sat   <= 1'b0;
                            r_sample_ready <= 1'b1;
                            r_state        <= COLLECT;
                        end else begin
                            r_idx        <= w_next_idx;
                            r_result     <= w_q_next[15:0];
                            r_result_sat <= w_q_next[16];
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign sampleReadyOut = r_sample_ready;
    assign firStartOut    = r_fir_start;
    assign firDataOut     = r_fir_data;
    assign resultOut      = r_result;
    assign resultValidOut = r_result_valid;
    assign resultSatOut   = r_result_sat;

endmodule

// File: tb/tb_fir_block_driver.sv
// Directed bench for fir_block_driver (SAMPLES_NUM=4, OUT_SHIFT=15), one line per transaction.
module tb_fir_block_driver;
    logic         clkIn = 1'b0;
    logic         resetIn = 1'b1;
    logic [15:0]  sampleIn = '0;
    logic         sampleValidIn = 1'b0;
    logic         sampleReadyOut;
    logic         firStartOut;
    logic         firBusyIn = 1'b0;
    logic         firDoneIn = 1'b0;
    logic [63:0]  firDataOut;
    logic [127:0] firDataIn = '0;
    logic [15:0]  resultOut;
    logic         resultValidOut;
    logic         resultReadyIn = 1'b0;
    logic         resultSatOut;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIR_DRIVER_ROUND_EN
    localparam logic [15:0] Q_A = 16'd3;
`else
    localparam logic [15:0] Q_A = 16'd2;
`endif

    fir_block_driver #(.SAMPLES_NUM(4), .OUT_SHIFT(15)) dut (
        .clkIn(clkIn), .resetIn(resetIn),
        .sampleIn(sampleIn), .sampleValidIn(sampleValidIn), .sampleReadyOut(sampleReadyOut),
        .firStartOut(firStartOut), .firBusyIn(firBusyIn), .firDoneIn(firDoneIn),
        .firDataOut(firDataOut), .firDataIn(firDataIn),
        .resultOut(resultOut), .resultValidOut(resultValidOut),
        .resultReadyIn(resultReadyIn), .resultSatOut(resultSatOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic send_sample(input logic [15:0] s);
        bit done = 0;
        sampleIn      = s;
        sampleValidIn = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            if (sampleReadyOut) done = 1;
            tick();
        end
        sampleValidIn = 1'b0;
        check("sample_accept_timeout", 64'(done), 64'd1);
        $display("sample 0x%04h sent", s);
    endtask

    task automatic pulse_done(input logic [127:0] data);
        firDataIn = data;
        firDoneIn = 1'b1;
        tick();
        firDoneIn = 1'b0;
        firDataIn = '0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] v, input logic s);
        check({tag, "_valid"}, 64'(resultValidOut), 64'd1);
        check({tag, "_value"}, 64'(resultOut), 64'(v));
        check({tag, "_sat"}, 64'(resultSatOut), 64'(s));
        $display("result %s: 0x%04h sat=%0b", tag, resultOut, resultSatOut);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(sampleReadyOut), 64'd0);
        check({tag, "_start"}, 64'(firStartOut), 64'd0);
        check({tag, "_data"}, firDataOut, 64'd0);
        check({tag, "_result"}, 64'(resultOut), 64'd0);
        check({tag, "_valid"}, 64'(resultValidOut), 64'd0);
        check({tag, "_sat"}, 64'(resultSatOut), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        check_reset_values("rst");
        resetIn = 1'b0;
        tick();
        check("ready_after_reset", 64'(sampleReadyOut), 64'd1);

        // Packing and start pulse
        send_sample(16'h0001);
        send_sample(16'h0002);
        send_sample(16'h0003);
        send_sample(16'h0004);
        check("pack_data", firDataOut, 64'h0004_0003_0002_0001);
        check("pack_start", 64'(firStartOut), 64'd1);
        check("pack_ready_low", 64'(sampleReadyOut), 64'd0);
        tick();
        check("start_one_cycle", 64'(firStartOut), 64'd0);
        check("ready_stays_low", 64'(sampleReadyOut), 64'd0);

        // Quantization, ordering, backpressure
        pulse_done({32'h0001_4000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_8000});
        check_result("A", Q_A, 1'b0);
        tick();
        check_result("A_stall", Q_A, 1'b0);
        resultReadyIn = 1'b1; tick(); resultReadyIn = 1'b0;
        check_result("B", 16'h7FFF, 1'b1);
        tick();
        check_result("B_stall", 16'h7FFF, 1'b1);
        resultReadyIn = 1'b1; tick(); resultReadyIn = 1'b0;
        check_result("C", 16'h8000, 1'b1);
        tick();
        check_result("C_stall", 16'h8000, 1'b1);
        resultReadyIn = 1'b1; tick(); resultReadyIn = 1'b0;
        check_result("D", 16'hFFFF, 1'b0);
        tick();
        check_result("D_stall", 16'hFFFF, 1'b0);
        check("ready_low_in_emit", 64'(sampleReadyOut), 64'd0);
        check("data_held_in_emit", firDataOut, 64'h0004_0003_0002_0001);
        resultReadyIn = 1'b1; tick(); resultReadyIn = 1'b0;
        check("valid_low_after_D", 64'(resultValidOut), 64'd0);
        check("ready_after_emit", 64'(sampleReadyOut), 64'd1);

        // Busy hold-off
        firBusyIn = 1'b1;
        send_sample(16'h0005);
        send_sample(16'h0006);
        send_sample(16'h0007);
        send_sample(16'h0008);
        check("busy_start_0", 64'(firStartOut), 64'd0);
        for (int c = 1; c < 5; c++) begin
            tick();
            check($sformatf("busy_start_%0d", c), 64'(firStartOut), 64'd0);
        end
        firBusyIn = 1'b0;
        tick();
        check("busy_release_start", 64'(firStartOut), 64'd1);
        check("busy_data", firDataOut, 64'h0008_0007_0006_0005);
        begin
            int pulses = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (firStartOut) pulses++;
            end
            check("busy_extra_pulses", 64'(pulses), 64'd0);
        end
        $display("busy hold-off block started");

        // Mid-operation reset while in WAIT, then a stale done
        resetIn = 1'b1; tick(); resetIn = 1'b0;
        check_reset_values("midrst");
        pulse_done({32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000});
        check("stale_done_valid", 64'(resultValidOut), 64'd0);
        check("ready_after_midrst", 64'(sampleReadyOut), 64'd1);
        tick();
        check("stale_done_valid2", 64'(resultValidOut), 64'd0);

        // Spurious done in COLLECT does not disturb the count
        send_sample(16'h0010);
        send_sample(16'h0020);
        pulse_done({32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
        check("spurious_valid", 64'(resultValidOut), 64'd0);
        check("spurious_ready", 64'(sampleReadyOut), 64'd1);
        send_sample(16'h0030);
        check("spurious_no_start", 64'(firStartOut), 64'd0);
        send_sample(16'h0040);
        check("spurious_data", firDataOut, 64'h0040_0030_0020_0010);
        check("spurious_start", 64'(firStartOut), 64'd1);
        tick();

        // Back-to-back emission
        pulse_done({32'h0000_8000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000});
        resultReadyIn = 1'b1;
        check_result("E0", 16'h0001, 1'b0);
        tick();
        check_result("E1", 16'h0002, 1'b0);
        tick();
        check_result("E2", 16'hFFFE, 1'b0);
        tick();
        check_result("E3", 16'h0000, 1'b0);
        tick();
        resultReadyIn = 1'b0;
        check("b2b_valid_low", 64'(resultValidOut), 64'd0);
        check("b2b_ready", 64'(sampleReadyOut), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_block_driver.md
# fir_block_driver

Stream-side adapter sitting in front of and behind the 16-bit block FIR core. Collects a serial stream of signed 16-bit samples into a block of `SAMPLES_NUM`, launches the core with a one-cycle start, and waits for its done pulse. It then captures the `SAMPLES_NUM` 32-bit results, quantizes each back to signed 16-bit, and emits them serially over a valid/ready handshake.

## Interface
- `SAMPLES_NUM`, 4: samples per block (1..8); must match the core.
- `OUT_SHIFT`, 15: arithmetic right shift applied to each 32-bit result (1..31).

- `clkIn` in 1: single clock; all logic on rising edge.
- `resetIn` in 1: synchronous, active-high reset.
- `sampleIn` in 16: signed input sample.
- `sampleValidIn` in 1: `sampleIn` valid.
- `sampleReadyOut` out 1: block accepts a sample.
- `firStartOut` out 1: start pulse to core.
- `firBusyIn` in 1: core busy.
- `firDoneIn` in 1: core done pulse (one cycle).
- `firDataOut` out 16*`SAMPLES_NUM`: packed sample block to core.
- `firDataIn` in 32*`SAMPLES_NUM`: packed results from core.
- `resultOut` out 16: quantized signed result.
- `resultValidOut` out 1: `resultOut` valid.
- `resultReadyIn` in 1: downstream accepts result.
- `resultSatOut` out 1: current `resultOut` was saturated; qualified by `resultValidOut`.

## Operation
- Four states, in order `COLLECT` → `START` → `WAIT` → `EMIT` → `COLLECT`.
- **COLLECT**
  - `sampleReadyOut`=1.
  - Each accepted sample (`sampleValidIn && sampleReadyOut`) number k (k=0 first in block) is written to `firDataOut[16*k +: 16]`.
  - After sample `SAMPLES_NUM`-1 is accepted, go to `START`.
- **START**
  - `sampleReadyOut`=0.
  - While `firBusyIn`=1, stay and hold `firStartOut`=0.
  - When `firBusyIn`=0, assert `firStartOut` for exactly one cycle, then go to `WAIT`.
- **WAIT**
  - On `firDoneIn`=1, capture `firDataIn` into the result register and go to `EMIT`.
  - `firBusyIn` is ignored in this state.
- **EMIT**
  - Element i (i=0 first) is `firDataIn[32*(SAMPLES_NUM-1-i) +: 32]`.
  - Quantize element i, present it on `resultOut` with `resultValidOut`=1, and advance on `resultReadyIn`.
  - After the last element is accepted, go to `COLLECT`.
- **Quantization** (computed at 33-bit signed width)
  - Sign-extend the element to 33 bits, optionally add the rounding constant (see Configuration), then arithmetic-shift right by `OUT_SHIFT`.
  - Saturate to [-32768, 32767]; `resultSatOut`=1 when clipped.
- `firDataOut` holds its value from block completion until the first sample of the next block is accepted.
- `firDoneIn` outside `WAIT` is ignored; no capture, no state change.
- No overlap between blocks: input is stalled from block completion until the last result is accepted.

## Timing
- **Reset values:** `sampleReadyOut`=0, `firStartOut`=0, `firDataOut`=0, `resultOut`=0, `resultValidOut`=0, `resultSatOut`=0; state `COLLECT`, counters 0.
- `sampleReadyOut` rises 1 cycle after `resetIn` deasserts.
- All outputs are registered.
- **Input to start:** last sample accepted at edge N → `firStartOut`=1 in cycle N+1, provided `firBusyIn`=0.
- **Done to first result:** `firDoneIn` high in cycle D → `resultValidOut`=1 in cycle D+1.
- **Result handshake:** `resultOut`, `resultSatOut` and `resultValidOut` hold stable while `resultValidOut && !resultReadyIn`. Back-to-back acceptance gives one result per cycle.
- **Return to input:** last result accepted at edge E → `sampleReadyOut`=1 in cycle E+1.
- **Reset mid-operation:** `resetIn` sampled high in any state discards the partial block and captured results and forces reset values on the next edge. A core start already issued is abandoned; its later `firDoneIn` is ignored because the state is no longer `WAIT`.

## Configuration
- `FIR_DRIVER_ROUND_EN` defined: add 2^(`OUT_SHIFT`-1) before the shift (round half up).
- `FIR_DRIVER_ROUND_EN` undefined: no addition; pure arithmetic shift (floor).
- Saturation and all timing are identical in both builds.

## Test plan
- **Packing:** reset, then stream samples 0x0001, 0x0002, 0x0003, 0x0004 with `SAMPLES_NUM`=4 → `firDataOut`=0x0004_0003_0002_0001. `firStartOut` is a single pulse in the cycle after the 4th accept, and `sampleReadyOut`=0 from then on.
- **Busy hold-off:** hold `firBusyIn`=1 for 5 cycles after the block completes → no `firStartOut` during those cycles; exactly one pulse in the first cycle with `firBusyIn`=0.
- **Quantization, `OUT_SHIFT`=15:**
  - Element 0x00014000 → `resultOut`=3 with `FIR_DRIVER_ROUND_EN`, 2 without.
  - Element 0x7FFFFFFF → `resultOut`=0x7FFF with `resultSatOut`=1.
  - Element 0x80000000 → `resultOut`=0x8000 with `resultSatOut`=1.
  - Element 0xFFFF8000 → `resultOut`=0xFFFF with `resultSatOut`=0.
- **Ordering and backpressure:** drive `firDataIn` = {A,B,C,D} with A in the MSBs and toggle `resultReadyIn` every other cycle → outputs in order A, B, C, D. Values stay stable while stalled; `sampleReadyOut` rises one cycle after D is accepted.
- **Spurious done:** pulse `firDoneIn` during `COLLECT` → no `resultValidOut`, and the sample count is unaffected.
- **Mid-operation reset:** assert `resetIn` for 1 cycle during `WAIT`, then pulse `firDoneIn` → all outputs at reset values, no results emitted, and the next block of 4 samples is processed normally.
